// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU opcodes, forwarding selects and control-bundle bit positions
// for the ID/EX operand stage.
package id_ex_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned REG_AW_DEF = 3;

  // opALU = {unsigned_set, inva, invb, selOp[1:0]}
  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SLTU = 5'b10111;
  localparam logic [4:0] OP_NOR  = 5'b01100;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MWB = 2'b01,
    FWD_EXM = 2'b10
  } fwd_sel_e;

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg}
  localparam int unsigned CTRL_REG_WRITE  = 3;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-slot bundle presented by the ID stage to the ID/EX operand stage.
interface id_ex_operand_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [4:0]        id_op_alu;
  logic [3:0]        id_ctrl;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data,
           id_rt_data, id_imm, id_alu_src, id_op_alu, id_ctrl
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data,
           id_rt_data, id_imm, id_alu_src, id_op_alu, id_ctrl
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Forwarding select and data mux for one source operand; register 0 never forwards.
module fwd_mux
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [DATA_W-1:0] mwb_wdata,
  output logic [DATA_W-1:0] data_o
);

  fwd_sel_e sel;

  // Pick the youngest producer of src_addr; EX/MEM outranks MEM/WB
  always_comb begin
    sel = FWD_REG;
    if (exm_reg_write && (exm_rd_addr != '0) && (exm_rd_addr == src_addr)) begin
      sel = FWD_EXM;
    end else if (mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == src_addr)) begin
      sel = FWD_MWB;
    end
  end

  // Data mux driven by the select
  always_comb begin
    case (sel)
      FWD_EXM: data_o = exm_result;
      FWD_MWB: data_o = mwb_wdata;
      default: data_o = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and load-use detection.
module id_ex_operand_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  id_ex_operand_stage_if.slave  id,
  input  logic                  exm_reg_write,
  input  logic [REG_AW-1:0]     exm_rd_addr,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_AW-1:0]     mwb_rd_addr,
  input  logic [DATA_W-1:0]     mwb_wdata,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [4:0]            alu_op,
  output logic                  ex_valid,
  output logic [REG_AW-1:0]     ex_rd_addr,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [3:0]            ex_ctrl,
  output logic                  hazard_o
);

  logic              valid_q,   valid_d;
  logic [3:0]        ctrl_q,    ctrl_d;
  logic [4:0]        op_q,      op_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              alu_src_q, alu_src_d;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // Next-state: flush loads a bubble, stall holds, otherwise capture decode
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    op_d      = op_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    alu_src_d = alu_src_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      op_d      = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      alu_src_d = 1'b0;
    end else if (!stall_i) begin
      valid_d   = id.id_valid;
      ctrl_d    = id.id_ctrl;
      op_d      = id.id_op_alu;
      rs_addr_d = id.id_rs_addr;
      rt_addr_d = id.id_rt_addr;
      rd_addr_d = id.id_rd_addr;
      rs_data_d = id.id_rs_data;
      rt_data_d = id.id_rt_data;
      imm_d     = id.id_imm;
      alu_src_d = id.id_alu_src;
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      op_q      <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      alu_src_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      op_q      <= op_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alu_src_q <= alu_src_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_addr      (rs_addr_q),
    .reg_data      (rs_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .mwb_wdata     (mwb_wdata),
    .data_o        (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_addr      (rt_addr_q),
    .reg_data      (rt_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .mwb_wdata     (mwb_wdata),
    .data_o        (rt_fwd)
  );

  // Operand outputs and load-use detection against the instruction now in decode
  always_comb begin
    alu_a         = rs_fwd;
    alu_b         = alu_src_q ? imm_q : rt_fwd;
    ex_store_data = rt_fwd;
    alu_op        = op_q;
    ex_valid      = valid_q;
    ex_rd_addr    = rd_addr_q;
    ex_ctrl       = ctrl_q;
    hazard_o      = valid_q && ctrl_q[CTRL_MEM_READ] && (rd_addr_q != '0) && id.id_valid &&
                    ((rd_addr_q == id.id_rs_addr) || (rd_addr_q == id.id_rt_addr));
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed-vector bench for id_ex_operand_stage with a queue-based scoreboard.
module tb_id_ex_operand_stage;
  import id_ex_pkg::*;

  typedef struct packed {
    logic       rst, stall, flush, valid;
    logic [2:0] rs, rt, rd;
    logic [7:0] rsd, rtd, imm;
    logic       alu_src;
    logic [4:0] op;
    logic [3:0] ctrl;
    logic       exm_we;
    logic [2:0] exm_rd;
    logic [7:0] exm_res;
    logic       mwb_we;
    logic [2:0] mwb_rd;
    logic [7:0] mwb_wd;
  } in_t;

  typedef struct packed {
    logic [7:0] a, b;
    logic [4:0] op;
    logic       v;
    logic [2:0] rd;
    logic [7:0] st;
    logic [3:0] ctrl;
    logic       haz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, stall_i, flush_i;
  logic       exm_reg_write, mwb_reg_write;
  logic [2:0] exm_rd_addr, mwb_rd_addr;
  logic [7:0] exm_result, mwb_wdata;
  logic [7:0] alu_a, alu_b, ex_store_data;
  logic [4:0] alu_op;
  logic       ex_valid, hazard_o;
  logic [2:0] ex_rd_addr;
  logic [3:0] ex_ctrl;

  int unsigned total = 0;
  int unsigned bad   = 0;

  exp_t  exp_q[$];
  string name_q[$];
  in_t   cur;

  id_ex_operand_stage_if #(.DATA_W(8), .REG_AW(3)) id_bus ();

  id_ex_operand_stage #(.DATA_W(8), .REG_AW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .id            (id_bus.slave),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .mwb_wdata     (mwb_wdata),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .ex_rd_addr    (ex_rd_addr),
    .ex_store_data (ex_store_data),
    .ex_ctrl       (ex_ctrl),
    .hazard_o      (hazard_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op,
                              input logic v, input logic [2:0] rd, input logic [7:0] st,
                              input logic [3:0] ctrl, input logic haz);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.v = v; e.rd = rd; e.st = st; e.ctrl = ctrl; e.haz = haz;
    return e;
  endfunction

  task automatic chk(input string n, input string f, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h", n, f, act, want);
    end
  endtask

  // Monitor: outputs settle after the edge; compare on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, "alu_a",   alu_a,              e.a);
      chk(n, "alu_b",   alu_b,              e.b);
      chk(n, "alu_op",  {3'b0, alu_op},     {3'b0, e.op});
      chk(n, "valid",   {7'b0, ex_valid},   {7'b0, e.v});
      chk(n, "rd",      {5'b0, ex_rd_addr}, {5'b0, e.rd});
      chk(n, "store",   ex_store_data,      e.st);
      chk(n, "ctrl",    {4'b0, ex_ctrl},    {4'b0, e.ctrl});
      chk(n, "hazard",  {7'b0, hazard_o},   {7'b0, e.haz});
    end
  end

  // Capture-side inputs change after the falling edge, forwarding sources after the rising edge
  task automatic run(input string n, input exp_t e);
    @(negedge clk);
    #1;
    rst               = cur.rst;
    stall_i           = cur.stall;
    flush_i           = cur.flush;
    id_bus.id_valid   = cur.valid;
    id_bus.id_rs_addr = cur.rs;
    id_bus.id_rt_addr = cur.rt;
    id_bus.id_rd_addr = cur.rd;
    id_bus.id_rs_data = cur.rsd;
    id_bus.id_rt_data = cur.rtd;
    id_bus.id_imm     = cur.imm;
    id_bus.id_alu_src = cur.alu_src;
    id_bus.id_op_alu  = cur.op;
    id_bus.id_ctrl    = cur.ctrl;
    @(posedge clk);
    #1;
    exm_reg_write = cur.exm_we;
    exm_rd_addr   = cur.exm_rd;
    exm_result    = cur.exm_res;
    mwb_reg_write = cur.mwb_we;
    mwb_rd_addr   = cur.mwb_rd;
    mwb_wdata     = cur.mwb_wd;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    cur = '0;
    cur.rst = 1'b1;
    run("rst_a", ex(8'h00, 8'h00, 5'b0, 0, 3'd0, 8'h00, 4'h0, 0));
    run("rst_b", ex(8'h00, 8'h00, 5'b0, 0, 3'd0, 8'h00, 4'h0, 0));

    cur.rst = 1'b0; cur.valid = 1'b1; cur.rs = 3'd1; cur.rt = 3'd2; cur.rd = 3'd4;
    cur.rsd = 8'h12; cur.rtd = 8'h34; cur.op = OP_ADD; cur.ctrl = 4'b1000;
    run("load", ex(8'h12, 8'h34, OP_ADD, 1, 3'd4, 8'h34, 4'h8, 0));

    cur.rs = 3'd3; cur.rt = 3'd5; cur.rd = 3'd6; cur.rsd = 8'h11; cur.rtd = 8'h22; cur.op = OP_SUB;
    cur.exm_we = 1'b1; cur.exm_rd = 3'd3; cur.exm_res = 8'hA5;
    run("fwd_exm", ex(8'hA5, 8'h22, OP_SUB, 1, 3'd6, 8'h22, 4'h8, 0));

    cur.stall = 1'b1; cur.mwb_we = 1'b1; cur.mwb_rd = 3'd3; cur.mwb_wd = 8'h5A;
    run("fwd_both", ex(8'hA5, 8'h22, OP_SUB, 1, 3'd6, 8'h22, 4'h8, 0));

    cur.exm_we = 1'b0;
    run("fwd_mwb", ex(8'h5A, 8'h22, OP_SUB, 1, 3'd6, 8'h22, 4'h8, 0));

    cur.stall = 1'b0; cur.rs = 3'd1; cur.rt = 3'd0; cur.rd = 3'd7; cur.rsd = 8'h01; cur.rtd = 8'h3C;
    cur.op = OP_OR; cur.ctrl = 4'b0010;
    cur.exm_we = 1'b1; cur.exm_rd = 3'd0; cur.exm_res = 8'hFF;
    cur.mwb_we = 1'b1; cur.mwb_rd = 3'd0; cur.mwb_wd = 8'hEE;
    run("reg0", ex(8'h01, 8'h3C, OP_OR, 1, 3'd7, 8'h3C, 4'h2, 0));

    cur.rs = 3'd1; cur.rt = 3'd4; cur.rd = 3'd1; cur.rsd = 8'h10; cur.rtd = 8'h20; cur.imm = 8'h07;
    cur.alu_src = 1'b1; cur.op = OP_ADD;
    cur.exm_we = 1'b1; cur.exm_rd = 3'd4; cur.exm_res = 8'h99; cur.mwb_we = 1'b0;
    run("imm", ex(8'h10, 8'h07, OP_ADD, 1, 3'd1, 8'h99, 4'h2, 0));

    cur.rs = 3'd1; cur.rt = 3'd3; cur.rd = 3'd2; cur.rsd = 8'h00; cur.rtd = 8'h00; cur.imm = 8'h04;
    cur.ctrl = 4'b1101; cur.exm_we = 1'b0;
    run("lw", ex(8'h00, 8'h04, OP_ADD, 1, 3'd2, 8'h00, 4'hD, 0));

    cur.stall = 1'b1; cur.rt = 3'd2; cur.rd = 3'd5; cur.rsd = 8'h77; cur.rtd = 8'h88; cur.imm = 8'h55;
    cur.op = OP_SLT; cur.ctrl = 4'b0000; cur.alu_src = 1'b0;
    run("luse_rt", ex(8'h00, 8'h04, OP_ADD, 1, 3'd2, 8'h00, 4'hD, 1));

    cur.valid = 1'b0; cur.rsd = 8'h66;
    run("luse_noval", ex(8'h00, 8'h04, OP_ADD, 1, 3'd2, 8'h00, 4'hD, 0));

    cur.valid = 1'b1; cur.rs = 3'd2; cur.rt = 3'd0;
    run("luse_rs", ex(8'h00, 8'h04, OP_ADD, 1, 3'd2, 8'h00, 4'hD, 1));

    cur.flush = 1'b1; cur.exm_we = 1'b1; cur.exm_rd = 3'd0; cur.exm_res = 8'hFF;
    run("flush_stall", ex(8'h00, 8'h00, 5'b0, 0, 3'd0, 8'h00, 4'h0, 0));

    cur.flush = 1'b0; cur.stall = 1'b0; cur.rs = 3'd0; cur.rt = 3'd0; cur.rd = 3'd0;
    cur.rsd = 8'h0F; cur.rtd = 8'hF0; cur.op = OP_NOR; cur.ctrl = 4'b0100; cur.exm_we = 1'b0;
    run("lw_rd0", ex(8'h0F, 8'hF0, OP_NOR, 1, 3'd0, 8'hF0, 4'h4, 0));

    cur.rs = 3'd6; cur.rt = 3'd7; cur.rd = 3'd3; cur.rsd = 8'h81; cur.rtd = 8'h02; cur.op = OP_SLTU;
    cur.ctrl = 4'b1100;
    cur.exm_we = 1'b1; cur.exm_rd = 3'd6; cur.exm_res = 8'h44;
    cur.mwb_we = 1'b1; cur.mwb_rd = 3'd7; cur.mwb_wd = 8'hC3;
    run("split_fwd", ex(8'h44, 8'hC3, OP_SLTU, 1, 3'd3, 8'hC3, 4'hC, 0));

    cur.rst = 1'b1; cur.exm_we = 1'b0; cur.mwb_we = 1'b0;
    run("rst_mid", ex(8'h00, 8'h00, 5'b0, 0, 3'd0, 8'h00, 4'h0, 0));

    cur.rst = 1'b0; cur.rs = 3'd2; cur.rt = 3'd3; cur.rd = 3'd1; cur.rsd = 8'h05; cur.rtd = 8'h06;
    cur.op = OP_AND; cur.ctrl = 4'b1000;
    cur.mwb_we = 1'b1; cur.mwb_rd = 3'd2; cur.mwb_wd = 8'h09;
    run("post_rst", ex(8'h09, 8'h06, OP_AND, 1, 3'd1, 8'h06, 4'h8, 0));

    cur.flush = 1'b1;
    run("flush", ex(8'h00, 8'h00, 5'b0, 0, 3'd0, 8'h00, 4'h0, 0));

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
ID/EX pipeline register and operand-forwarding front end that drives the 8-bit ALU's A, B and opALU inputs one cycle after decode. It also carries store data and memory/writeback control to EX/MEM, and flags load-use hazards to the pipeline controller.

Parameters:
DATA_W, 8, datapath and operand width
REG_AW, 3, register-file address width (register 0 is hardwired zero)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold all stage registers
flush_i  in  1  load a bubble
id_valid  in  1  decode slot holds a real instruction
id_rs_addr  in  REG_AW  source register 1
id_rt_addr  in  REG_AW  source register 2
id_rd_addr  in  REG_AW  destination register
id_rs_data  in  DATA_W  register-file read of rs
id_rt_data  in  DATA_W  register-file read of rt
id_imm  in  DATA_W  extended immediate
id_alu_src  in  1  1 = B operand from immediate
id_op_alu  in  5  ALU opcode {unsigned_set, inva, invb, selOp[1:0]}
id_ctrl  in  4  {reg_write, mem_read, mem_write, mem_to_reg}
exm_reg_write  in  1  EX/MEM stage writes a register
exm_rd_addr  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB stage writes a register
mwb_rd_addr  in  REG_AW  MEM/WB destination
mwb_wdata  in  DATA_W  MEM/WB writeback value
alu_a  out  DATA_W  forwarded A operand to ALU
alu_b  out  DATA_W  forwarded rt or immediate to ALU
alu_op  out  5  registered opALU
ex_valid  out  1  EX slot valid
ex_rd_addr  out  REG_AW  registered destination
ex_store_data  out  DATA_W  forwarded rt (always, independent of alu_src)
ex_ctrl  out  4  registered control bundle
hazard_o  out  1  load-use hazard detected (combinational)

Behaviour:
- All state changes on posedge clk. Priority: rst > flush_i > stall_i > load.
- rst or flush_i: valid, ctrl, opALU, addresses, data, imm and alu_src all cleared to 0. alu_a, alu_b and ex_store_data therefore read 0 unless forwarding matches register 0, which never forwards. hazard_o is 0 after reset.
- stall_i alone: every register holds, and forwarded outputs keep tracking current exm/mwb inputs. flush_i together with stall_i gives a bubble.
- Load: capture all id_* fields. Latency from ID to ALU inputs is one cycle.
- Forwarding uses the registered rs/rt addresses.
  - Select 10 (EX/MEM) when exm_reg_write, exm_rd_addr != 0 and it equals the source.
  - Otherwise select 01 (MEM/WB) under the same rule with mwb_*.
  - Otherwise select 00 (registered read data).
  - EX/MEM wins when both match.
- alu_b = registered imm when alu_src = 1, else forwarded rt.
- hazard_o = ex_valid & ex_ctrl.mem_read & ex_rd_addr != 0 & id_valid & (ex_rd_addr == id_rs_addr | ex_rd_addr == id_rt_addr).
- The block does not act on hazard_o. The controller stalls IF/ID and asserts flush_i.
- Control fields pass through unmodified. A bubble has reg_write = 0, so it never becomes a forwarding source downstream.

Decomposition:
- Package id_ex_pkg holds DATA_W and REG_AW defaults.
- It holds the opALU constants: OP_AND 5'b00000, OP_OR 5'b00001, OP_ADD 5'b00010, OP_SUB 5'b00110, OP_SLT 5'b00111, OP_SLTU 5'b10111, OP_NOR 5'b01100.
- It holds the FWD_REG/FWD_MWB/FWD_EXM encodings (00/01/10) and the ctrl bit indices.
- One sub-module, fwd_mux, holds the select and data mux for one operand. It is instantiated twice (rs and rt).

Test Plan:
- Reset then idle: assert rst 2 cycles -> all outputs 0 and hazard_o = 0. Load id_rs_data = 8'h12, id_rt_data = 8'h34, OP_ADD, no forwarding matches -> next cycle alu_a = 8'h12, alu_b = 8'h34, alu_op = 5'b00010.
- EX/MEM forward: EX-stage rs = 3, exm_reg_write = 1, exm_rd_addr = 3, exm_result = 8'hA5 -> alu_a = 8'hA5. Also set mwb_rd_addr = 3, mwb_wdata = 8'h5A -> alu_a stays 8'hA5.
- Register 0 and immediate: rt = 0, exm_rd_addr = 0, exm_reg_write = 1, exm_result = 8'hFF -> ex_store_data = registered rt data. alu_src = 1, imm = 8'h07, rt forwarded 8'h99 -> alu_b = 8'h07, ex_store_data = 8'h99.
- Load-use: EX holds mem_read, rd = 2, valid; ID has rt = 2, id_valid = 1 -> hazard_o = 1. Same case with ex_rd_addr = 0 or id_valid = 0 -> hazard_o = 0.
- Stall/flush: stall_i = 1 for 3 cycles with changing id_* -> registered outputs unchanged. flush_i = 1 with stall_i = 1 -> ex_valid = 0, ex_ctrl = 0, alu_op = 0 next cycle.
- Reset mid-stream: rst asserted while ex_valid = 1 and ex_ctrl = 4'b1100 -> all registers 0 on the next edge.
